conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer_pkg.sv | 22 ++
 rtl/window_counter.sv | 43 ++++
 rtl/conv_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/conv_sequencer_pkg.sv
`default_nettype none
// conv_sequencer_pkg -- shared constants, FSM states and size check for the convolution sequencer.
// Rev 1.0
package conv_sequencer_pkg;

  localparam int PIPE_LAT = 3;
  localparam int MAX_N    = 32;
  localparam int MIN_N    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic size_ok(input logic [5:0] n);
    return (n >= 6'(MIN_N)) && (n <= 6'(MAX_N));
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_counter.sv
`default_nettype none
// window_counter -- phase/col/row cascade; phase 0..2, col and row 0..lim, wraps to zero after the last window.
// Rev 1.0
module window_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [4:0] lim,
  output logic [1:0] phase,
  output logic [4:0] col,
  output logic [4:0] row,
  output logic       last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 2'd0;
      col   <= 5'd0;
      row   <= 5'd0;
    end else if (clr) begin
      phase <= 2'd0;
      col   <= 5'd0;
      row   <= 5'd0;
    end else if (en) begin
      if (phase == 2'd2) begin
        phase <= 2'd0;
        if (col == lim) begin
          col <= 5'd0;
          row <= (row == lim) ? 5'd0 : row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end else begin
        phase <= phase + 2'd1;
      end
    end
  end

  assign last = (phase == 2'd2) && (col == lim) && (row == lim);

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// conv_sequencer -- issues 3x3 convolution windows over an NxN image and strobes result writes PIPE_LAT later.
// Rev 1.0
module conv_sequencer
  import conv_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       hold,
  input  logic [5:0] cfg_size,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic [1:0] phase,
  output logic       issue_valid,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  state_t              state, state_nxt;
  logic [5:0]          n_q;
  logic [4:0]          lim;
  logic [PIPE_LAT-1:0] vld_sr;
  logic                accept, kill, win_last, drain_last;
  logic                cnt_en, cnt_clr;

  assign lim        = 5'(n_q - 6'd3);
  assign accept     = (state == ST_IDLE) && start && !abort && size_ok(cfg_size);
  assign kill       = abort && ((state == ST_RUN) || (state == ST_DRAIN));
  assign wr_en      = vld_sr[PIPE_LAT-1];
  // The last write is the one with nothing younger still in flight.
  assign drain_last = (state == ST_DRAIN) && wr_en && (vld_sr[PIPE_LAT-2:0] == '0);

  window_counter u_window_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .lim   (lim),
    .phase (phase),
    .col   (col),
    .row   (row),
    .last  (win_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)                         state_nxt = ST_IDLE;
        else if (issue_valid && win_last)  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)           state_nxt = ST_IDLE;
        else if (drain_last) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == ST_RUN) || (state == ST_DRAIN);
    done        = (state == ST_DONE);
    // hold only bites at a window boundary so a started window always completes.
    issue_valid = (state == ST_RUN) && !(hold && (phase == 2'd0));
    cnt_en      = issue_valid;
    cnt_clr     = kill || accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= 6'(MAX_N);
      cfg_err <= 1'b0;
      vld_sr  <= '0;
      wr_addr <= 10'd0;
    end else begin
      cfg_err <= (state == ST_IDLE) && start && !abort && !size_ok(cfg_size);
      if (accept) n_q <= cfg_size;

      if (kill) vld_sr <= '0;
      else      vld_sr <= {vld_sr[PIPE_LAT-2:0], issue_valid && (phase == 2'd2)};

      if (kill || accept || drain_last) wr_addr <= 10'd0;
      else if (wr_en)                   wr_addr <= wr_addr + 10'd1;
    end
  end

endmodule
`default_nettype wire
